median_filter_5x5_ctrl: RTL
===========================

Name: median_filter_5x5_ctrl

Overview:
- Frame-level sequencer for the 5x5 median datapath.
- Accepts a raster pixel stream and tracks the row and column position of each pixel.
- Issues the per-window valid strobe (drives done_i of median_filter_5x5_calc) once a full 5x5 neighbourhood exists.
- Counts returned results (done_o), tags each with its output coordinate, and signals frame completion.
- Sits between the pixel source / line-buffer window generator and median_filter_5x5_calc.

Parameters:
- IMG_W, 640, pixels per line; legal range 5..4096.
- IMG_H, 480, lines per frame; legal range 5..4096.
- CALC_LAT_MAX, 64, drain watchdog limit in cycles after the last input pixel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-high: rst_n=1 resets on the clk rising edge. The suffix is kept for consistency with existing blocks.
- start_i  in  1  one-cycle frame start; honoured only in IDLE.
- pix_valid_i  in  1  input pixel strobe; honoured only in RUN.
- shift_en_o  out  1  combinational: pix_valid_i and state is RUN; advances the line buffers and window.
- win_valid_o  out  1  registered; drives calc done_i.
- calc_done_i  in  1  calc done_o (one result per pulse, in order).
- res_valid_o  out  1  registered copy of an accepted calc_done_i.
- res_x_o  out  12  output column of the result, 0..IMG_W-5.
- res_y_o  out  12  output row of the result, 0..IMG_H-5.
- busy_o  out  1  state is not IDLE.
- frame_done_o  out  1  one-cycle pulse.
- err_o  out  1  sticky error flag; cleared only by reset or start_i.

Behaviour:
- Reset: state IDLE. All counters 0. win_valid_o, res_valid_o, frame_done_o and err_o are 0. res_x_o and res_y_o are 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start_i. This clears the col/row/issued/returned counters and err_o.
- RUN: each pix_valid_i increments col. At col=IMG_W-1, col wraps to 0 and row increments.
- Window issue: win_valid_o=1 in the cycle after a pixel is accepted at (col, row) with col>=4 and row>=4; otherwise 0. The issued counter increments on each such strobe. Window centre is (col-2, row-2).
- RUN -> DRAIN in the cycle after the pixel at (IMG_W-1, IMG_H-1) is accepted. That pixel's window strobe still occurs.
- Returned results: calc_done_i is accepted in RUN and DRAIN.
  - Each accepted pulse gives res_valid_o=1 on the next cycle, with res_x_o/res_y_o equal to the current out-coordinate counter.
  - The out-coordinate counter then advances: x wraps at IMG_W-5, then y increments.
  - The returned counter increments.
- Overrun error: calc_done_i while returned equals issued sets err_o=1. No res_valid_o is produced and no counter advances.
- Stray input: calc_done_i in IDLE or DONE is ignored and does not set err_o.
- DRAIN -> DONE when returned reaches (IMG_W-4)*(IMG_H-4). The check includes the increment made in the same cycle.
- Watchdog: a DRAIN cycle counter runs from 0. If it reaches CALC_LAT_MAX before the frame completes, err_o is set and the state goes to DONE.
- DONE: frame_done_o=1 for exactly one cycle, then the state returns to IDLE.
- pix_valid_i outside RUN: ignored; shift_en_o stays 0.
- start_i outside IDLE: ignored.
- Simultaneous pix_valid_i and calc_done_i in RUN: both are processed independently.
- rst_n asserted mid-frame: immediate return to reset values on the next edge; no frame_done_o pulse.
- Arithmetic: counters are 12-bit unsigned and the issued/returned counters are 24-bit. The window count is computed at elaboration. Equality compares are used for wrap detection; there are no subtractions at runtime.

Decomposition:
- Shared package median_ctrl_pkg holds:
  - state encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - COORD_W=12 and CNT_W=24;
  - a function computing the window count from IMG_W and IMG_H.
- One sub-module: raster_counter (parameterised LIMIT_X, LIMIT_Y; inputs clr, inc; outputs x, y, last). It is instantiated twice: once for input col/row and once for output res coordinates.

Test Plan:
1. IMG_W=8, IMG_H=6, with start_i then 48 consecutive pix_valid_i:
   - win_valid_o pulses 8 times: one cycle after pixels (4,4)..(7,4) and (4,5)..(7,5);
   - busy_o=1 from the cycle after start_i.
2. Same frame, with calc_done_i returned 3 cycles after each window:
   - res (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1);
   - frame_done_o pulses once after the 8th result; err_o=0.
3. Gapped input: pix_valid_i at 50% duty, random pattern:
   - win_valid_o count and positions are identical to scenario 1;
   - shift_en_o high only on accepted pixels.
4. calc_done_i injected in RUN with returned equal to issued (e.g. before the first window):
   - err_o=1 and stays 1;
   - no res_valid_o; frame still completes normally.
5. Withhold the last result, CALC_LAT_MAX=16:
   - exactly 16 DRAIN cycles after the last pixel, err_o=1 and frame_done_o pulses; state returns to IDLE.
6. rst_n=1 asserted after 20 pixels:
   - next cycle busy_o=0 and all outputs are 0;
   - a fresh start_i then runs a full frame matching scenario 2.

Source files
------------

// File: rtl/median_ctrl_pkg.sv
// Shared definitions for the 5x5 median filter frame sequencer.
package median_ctrl_pkg;

  localparam int COORD_W = 12;
  localparam int CNT_W   = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  // Number of full 5x5 windows that fit in an img_w x img_h frame.
  function automatic logic [CNT_W-1:0] window_count(input int img_w, input int img_h);
    return CNT_W'((img_w - 4) * (img_h - 4));
  endfunction

endpackage

// File: rtl/median_filter_5x5_ctrl_raster_counter.sv
// Raster-order x/y position counter: x runs 0..LIMIT_X, then wraps and y advances.
module raster_counter
  import median_ctrl_pkg::*;
#(
  parameter int LIMIT_X = 7,
  parameter int LIMIT_Y = 5
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               clr,
  input  logic               inc,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(LIMIT_X);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(LIMIT_Y);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic               x_wrap;
  logic               y_wrap;

  assign x_wrap = (x_reg == MAX_X);
  assign y_wrap = (y_reg == MAX_Y);

  // Position update: clear wins over increment; wrap detection by equality only.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (inc) begin
      if (x_wrap) begin
        x_reg <= '0;
        y_reg <= y_wrap ? '0 : y_reg + ONE;
      end else begin
        x_reg <= x_reg + ONE;
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = x_wrap && y_wrap;

endmodule

// File: rtl/median_filter_5x5_ctrl.sv
// Frame sequencer for the 5x5 median datapath: tracks input raster position,
// strobes a window for every full neighbourhood, tags returned results and
// reports frame completion or drain timeout.
module median_filter_5x5_ctrl
  import median_ctrl_pkg::*;
#(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int CALC_LAT_MAX = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               pix_valid_i,
  output logic               shift_en_o,
  output logic               win_valid_o,
  input  logic               calc_done_i,
  output logic               res_valid_o,
  output logic [COORD_W-1:0] res_x_o,
  output logic [COORD_W-1:0] res_y_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               err_o
);

  localparam logic [CNT_W-1:0]   WIN_TOTAL = window_count(IMG_W, IMG_H);
  localparam logic [CNT_W-1:0]   WDOG_LAST = CNT_W'(CALC_LAT_MAX - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [COORD_W-1:0] WIN_EDGE  = COORD_W'(4);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   issued_reg;
  logic [CNT_W-1:0]   returned_reg;
  logic [CNT_W-1:0]   returned_next;
  logic [CNT_W-1:0]   drain_cnt_reg;
  logic               err_reg;
  logic               win_valid_reg;
  logic               res_valid_reg;
  logic [COORD_W-1:0] res_x_reg;
  logic [COORD_W-1:0] res_y_reg;

  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic               in_last;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;

  logic start_acc;
  logic res_phase;
  logic res_acc;
  logic overrun;
  logic win_hit;
  logic frame_complete;
  logic wdog_fire;

  assign start_acc  = (state_reg == IDLE) && start_i;
  assign shift_en_o = pix_valid_i && (state_reg == RUN);
  assign res_phase  = (state_reg == RUN) || (state_reg == DRAIN);
  // A result is only legal while some issued window is still outstanding.
  assign res_acc    = calc_done_i && res_phase && (returned_reg != issued_reg);
  assign overrun    = calc_done_i && res_phase && (returned_reg == issued_reg);
  assign win_hit    = shift_en_o && (col >= WIN_EDGE) && (row >= WIN_EDGE);

  assign returned_next  = res_acc ? returned_reg + CNT_ONE : returned_reg;
  assign frame_complete = (returned_next == WIN_TOTAL);
  assign wdog_fire      = (state_reg == DRAIN) && !frame_complete && (drain_cnt_reg == WDOG_LAST);

  raster_counter #(
    .LIMIT_X (IMG_W - 1),
    .LIMIT_Y (IMG_H - 1)
  ) u_in_pos (
    .clk  (clk),
    .srst (rst_n),
    .clr  (start_acc),
    .inc  (shift_en_o),
    .x    (col),
    .y    (row),
    .last (in_last)
  );

  raster_counter #(
    .LIMIT_X (IMG_W - 5),
    .LIMIT_Y (IMG_H - 5)
  ) u_out_pos (
    .clk  (clk),
    .srst (rst_n),
    .clr  (start_acc),
    .inc  (res_acc),
    .x    (out_x),
    .y    (out_y),
    .last ()
  );

  // Next-state logic for the frame sequence.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (shift_en_o && in_last) state_next = DRAIN;
      DRAIN:   if (frame_complete || wdog_fire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, window/result bookkeeping, drain watchdog and sticky error.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg     <= IDLE;
      issued_reg    <= '0;
      returned_reg  <= '0;
      drain_cnt_reg <= '0;
      err_reg       <= 1'b0;
      win_valid_reg <= 1'b0;
      res_valid_reg <= 1'b0;
      res_x_reg     <= '0;
      res_y_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      win_valid_reg <= win_hit;
      res_valid_reg <= res_acc;
      if (res_acc) begin
        res_x_reg <= out_x;
        res_y_reg <= out_y;
      end
      if (start_acc) begin
        issued_reg    <= '0;
        returned_reg  <= '0;
        drain_cnt_reg <= '0;
        err_reg       <= 1'b0;
      end else begin
        if (win_hit) issued_reg <= issued_reg + CNT_ONE;
        returned_reg <= returned_next;
        if (overrun || wdog_fire) err_reg <= 1'b1;
        drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + CNT_ONE : '0;
      end
    end
  end

  assign win_valid_o  = win_valid_reg;
  assign res_valid_o  = res_valid_reg;
  assign res_x_o      = res_x_reg;
  assign res_y_o      = res_y_reg;
  assign err_o        = err_reg;
  assign busy_o       = (state_reg != IDLE);
  assign frame_done_o = (state_reg == DONE);

endmodule
